// File: rtl/dae_error_monitor.sv
// dae_error_monitor: aligns the reference to the denoiser latency and reports
// per-frame signal, residual-error and raw-error energies over valid/ready.
module dae_error_monitor #(
    parameter int DATA_W      = 8,
    parameter int FRAME_LEN   = 1024,
    parameter int ALIGN_DELAY = 2,
    parameter int ACC_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] ref_sample,
    input  logic [DATA_W-1:0] noisy_sample,
    input  logic [DATA_W-1:0] den_sample,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  sig_energy,
    output logic [ACC_W-1:0]  err_energy,
    output logic [ACC_W-1:0]  raw_energy,
    output logic [15:0]       frame_count,
    output logic              overrun
);
    localparam int SQ_W   = 2*DATA_W+2;
    localparam int CNT_W  = $clog2(FRAME_LEN);
    localparam int FILL_W = $clog2(ALIGN_DELAY+1);

    typedef enum logic {FILL, ACCUM} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] dly [ALIGN_DELAY];
    logic [FILL_W-1:0] fill_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  sig_acc, err_acc, raw_acc, sig_nxt, err_nxt, raw_nxt;
    logic signed [SQ_W-1:0] ref_x, err_x, raw_x;
    logic [SQ_W-1:0] ref_sq, err_sq, raw_sq;
    logic acc_en, last;

    function automatic logic signed [SQ_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(SQ_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // Clamp at all-ones so long frames never wrap the accumulators.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [SQ_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W+1-SQ_W){1'b0}}, b};
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    assign ref_x  = sext(ref_sample);
    assign err_x  = sext(den_sample) - sext(dly[ALIGN_DELAY-1]);
    assign raw_x  = sext(noisy_sample) - ref_x;
    assign ref_sq = ref_x * ref_x;
    assign err_sq = err_x * err_x;
    assign raw_sq = raw_x * raw_x;

    assign sig_nxt = sat_add(sig_acc, ref_sq);
    assign err_nxt = sat_add(err_acc, err_sq);
    assign raw_nxt = sat_add(raw_acc, raw_sq);

    assign acc_en = state == ACCUM && in_valid;
    assign last   = acc_en && cnt == CNT_W'(FRAME_LEN-1);

    always_comb begin
        state_nxt = (state == FILL && in_valid && fill_cnt == FILL_W'(ALIGN_DELAY-1)) ? ACCUM : state;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FILL;
            fill_cnt    <= '0;
            cnt         <= '0;
            sig_acc     <= '0;
            err_acc     <= '0;
            raw_acc     <= '0;
            for (int i = 0; i < ALIGN_DELAY; i++) dly[i] <= '0;
            res_valid   <= 1'b0;
            sig_energy  <= '0;
            err_energy  <= '0;
            raw_energy  <= '0;
            frame_count <= '0;
            overrun     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (in_valid) begin
                dly[0] <= ref_sample;
                for (int i = 1; i < ALIGN_DELAY; i++) dly[i] <= dly[i-1];
            end
            if (state == FILL && in_valid) fill_cnt <= fill_cnt + 1'b1;
            if (acc_en) begin
                cnt     <= last ? '0 : cnt + 1'b1;
                sig_acc <= last ? '0 : sig_nxt;
                err_acc <= last ? '0 : err_nxt;
                raw_acc <= last ? '0 : raw_nxt;
            end
            // A completing frame wins over acceptance so no result is lost.
            if (last) begin
                sig_energy  <= sig_nxt;
                err_energy  <= err_nxt;
                raw_energy  <= raw_nxt;
                res_valid   <= 1'b1;
                frame_count <= frame_count + 1'b1;
                if (res_valid && !res_ready) overrun <= 1'b1;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dae_error_monitor.sv
// tb_dae_error_monitor: randomized and directed checks of dae_error_monitor
// against a frame-sum reference model built from the accepted sample history.
module tb_dae_error_monitor;
    localparam int AD = 2, FL = 4, FL2 = 8, W2 = 18;

    logic clk = 0, rst = 0, in_valid = 0, res_ready = 0;
    logic [7:0] ref_s = 0, noisy_s = 0, den_s = 0;
    logic res_valid, overrun, res_valid2, overrun2;
    logic [31:0] sig, err, raw;
    logic [W2-1:0] sig2, err2, raw2;
    logic [15:0] fc, fc2;

    int checks = 0, failures = 0;
    int qr[$], qn[$], qd[$];
    logic m_valid, m_ovr;
    int m_fc;
    longint m_sig, m_err, m_raw;

    always #5 clk = ~clk;

    dae_error_monitor #(.DATA_W(8), .FRAME_LEN(FL), .ALIGN_DELAY(AD), .ACC_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ref_sample(ref_s), .noisy_sample(noisy_s),
        .den_sample(den_s), .res_valid(res_valid), .res_ready(res_ready), .sig_energy(sig),
        .err_energy(err), .raw_energy(raw), .frame_count(fc), .overrun(overrun));

    dae_error_monitor #(.DATA_W(8), .FRAME_LEN(FL2), .ALIGN_DELAY(AD), .ACC_W(W2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ref_sample(ref_s), .noisy_sample(noisy_s),
        .den_sample(den_s), .res_valid(res_valid2), .res_ready(res_ready), .sig_energy(sig2),
        .err_energy(err2), .raw_energy(raw2), .frame_count(fc2), .overrun(overrun2));

    // Energies of frame k (1-based) straight from the accepted-sample history.
    function automatic void frame_sums(input int fl, input int w, input int k,
                                       output longint s, output longint e, output longint r);
        longint mx = (longint'(1) << w) - 1;
        s = 0; e = 0; r = 0;
        for (int i = AD + (k-1)*fl; i < AD + k*fl; i++) begin
            s += qr[i]*qr[i];
            e += (qd[i]-qr[i-AD])*(qd[i]-qr[i-AD]);
            r += (qn[i]-qr[i])*(qn[i]-qr[i]);
        end
        if (s > mx) s = mx;
        if (e > mx) e = mx;
        if (r > mx) r = mx;
    endfunction

    task automatic cyc(input logic v, input logic rn, input logic rdy,
                       input logic [7:0] r, input logic [7:0] n, input logic [7:0] d);
        logic acc;
        in_valid = v; rst = rn; res_ready = rdy; ref_s = r; noisy_s = n; den_s = d;
        @(posedge clk);
        if (!rn) begin
            qr.delete(); qn.delete(); qd.delete();
            m_valid = 0; m_ovr = 0; m_fc = 0; m_sig = 0; m_err = 0; m_raw = 0;
        end else begin
            acc = m_valid && rdy;
            if (v) begin
                qr.push_back(int'($signed(r)));
                qn.push_back(int'($signed(n)));
                qd.push_back(int'($signed(d)));
            end
            if (v && qr.size() >= AD+FL && (qr.size()-AD) % FL == 0) begin
                if (m_valid && !rdy) m_ovr = 1;
                m_valid = 1;
                m_fc = (m_fc + 1) % 65536;
                frame_sums(FL, 32, (qr.size()-AD)/FL, m_sig, m_err, m_raw);
            end else if (acc) begin
                m_valid = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic samp(input logic [7:0] r, input logic [7:0] n, input logic [7:0] d, input logic rdy);
        cyc(1'b1, 1'b1, rdy, r, n, d);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++)
            cyc(1'($urandom), 1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset res_valid: got %b want 0", res_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset overrun: got %b want 0", overrun); end
        checks++; if (fc !== 16'd0) begin failures++; $display("FAIL reset frame_count: got %0d want 0", fc); end
        checks++; if (sig !== 32'd0) begin failures++; $display("FAIL reset sig_energy: got %0d want 0", sig); end
        checks++; if (err !== 32'd0) begin failures++; $display("FAIL reset err_energy: got %0d want 0", err); end
        checks++; if (raw !== 32'd0) begin failures++; $display("FAIL reset raw_energy: got %0d want 0", raw); end
        for (int i = 0; i < 5; i++) begin
            samp(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            checks++;
            if (res_valid !== 1'b0) begin failures++; $display("FAIL reset no-result sample %0d: got %b want 0", i, res_valid); end
        end
    endtask

    task automatic test_constant();
        do_reset();
        for (int i = 0; i < 6; i++) samp(8'd10, 8'd13, 8'd10, 1'b0);
        checks++; if (sig !== 32'd400) begin failures++; $display("FAIL const sig_energy: got %0d want 400", sig); end
        checks++; if (raw !== 32'd36) begin failures++; $display("FAIL const raw_energy: got %0d want 36", raw); end
        checks++; if (err !== 32'd0) begin failures++; $display("FAIL const err_energy: got %0d want 0", err); end
        checks++; if (fc !== 16'd1) begin failures++; $display("FAIL const frame_count: got %0d want 1", fc); end
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL const res_valid: got %b want 1", res_valid); end
    endtask

    task automatic test_alignment();
        int k = 0;
        logic v;
        do_reset();
        for (int c = 0; c < 50; c++) begin
            v = ($urandom_range(0, 9) < 7);
            cyc(v, 1'b1, 1'($urandom), 8'(k+1), 8'($urandom), (k >= 2) ? 8'(k-1) : 8'd0);
            if (v) k++;
            checks++;
            if (err !== 32'd0 || {res_valid, overrun, fc, sig, raw} !==
                {m_valid, m_ovr, 16'(m_fc), 32'(m_sig), 32'(m_raw)}) begin
                failures++;
                $display("FAIL align cycle %0d: got v=%b o=%b fc=%0d sig=%0d err=%0d raw=%0d want v=%b o=%b fc=%0d sig=%0d err=0 raw=%0d",
                         c, res_valid, overrun, fc, sig, err, raw, m_valid, m_ovr, m_fc, m_sig, m_raw);
            end
        end
        checks++;
        if (fc < 16'd3) begin failures++; $display("FAIL align frames seen: got %0d want >=3", fc); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 150; c++) begin
            cyc($urandom_range(0, 3) != 0, 1'b1, $urandom_range(0, 9) < 3,
                8'($urandom), 8'($urandom), 8'($urandom));
            checks++;
            if ({res_valid, overrun, fc, sig, err, raw} !==
                {m_valid, m_ovr, 16'(m_fc), 32'(m_sig), 32'(m_err), 32'(m_raw)}) begin
                failures++;
                $display("FAIL random cycle %0d: got v=%b o=%b fc=%0d sig=%0d err=%0d raw=%0d want v=%b o=%b fc=%0d sig=%0d err=%0d raw=%0d",
                         c, res_valid, overrun, fc, sig, err, raw, m_valid, m_ovr, m_fc, m_sig, m_err, m_raw);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < AD+FL2; i++) samp(8'h80, 8'h7F, 8'h00, 1'b0);
        checks++; if (raw2 !== 18'd262143) begin failures++; $display("FAIL sat raw_energy: got %0d want 262143", raw2); end
        checks++; if (sig2 !== 18'd131072) begin failures++; $display("FAIL sat sig_energy: got %0d want 131072", sig2); end
        checks++; if (err2 !== 18'd131072) begin failures++; $display("FAIL sat err_energy: got %0d want 131072", err2); end
        checks++; if ({res_valid2, overrun2, fc2} !== {1'b1, 1'b0, 16'd1}) begin
            failures++; $display("FAIL sat status: got v=%b o=%b fc=%0d want v=1 o=0 fc=1", res_valid2, overrun2, fc2); end
        checks++; if (raw !== 32'd260100) begin failures++; $display("FAIL sat wide raw_energy: got %0d want 260100", raw); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < AD+2*FL; i++) samp(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL bp overrun: got %b want 1", overrun); end
        checks++; if (fc !== 16'd2) begin failures++; $display("FAIL bp frame_count: got %0d want 2", fc); end
        checks++;
        if ({sig, err, raw} !== {32'(m_sig), 32'(m_err), 32'(m_raw)}) begin
            failures++; $display("FAIL bp frame2 values: got %0d/%0d/%0d want %0d/%0d/%0d", sig, err, raw, m_sig, m_err, m_raw); end
        cyc(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL bp accept res_valid: got %b want 0", res_valid); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL bp sticky overrun: got %b want 1", overrun); end
        do_reset();
        for (int i = 0; i < AD+FL; i++) samp(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        for (int i = 0; i < FL-1; i++) samp(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        samp(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp same-edge res_valid: got %b want 1", res_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL bp same-edge overrun: got %b want 0", overrun); end
        checks++;
        if ({fc, sig, err, raw} !== {16'd2, 32'(m_sig), 32'(m_err), 32'(m_raw)}) begin
            failures++; $display("FAIL bp same-edge values: got fc=%0d %0d/%0d/%0d want fc=2 %0d/%0d/%0d", fc, sig, err, raw, m_sig, m_err, m_raw); end
    endtask

    task automatic test_midreset();
        do_reset();
        for (int i = 0; i < AD+3; i++) samp(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        do_reset();
        for (int i = 0; i < AD+FL-1; i++) begin
            samp(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            checks++;
            if (res_valid !== 1'b0) begin failures++; $display("FAIL midreset early result at %0d: got %b want 0", i, res_valid); end
        end
        samp(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        checks++;
        if ({res_valid, fc, sig, err, raw} !== {1'b1, 16'd1, 32'(m_sig), 32'(m_err), 32'(m_raw)}) begin
            failures++; $display("FAIL midreset result: got v=%b fc=%0d %0d/%0d/%0d want v=1 fc=1 %0d/%0d/%0d",
                                 res_valid, fc, sig, err, raw, m_sig, m_err, m_raw); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_constant();
        test_alignment();
        test_random();
        test_saturation();
        test_backpressure();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
